tlb_inv_ctrl: RTL and testbench

Multi-cycle sequencer for the INVTLB instruction. It walks every TLB entry through the TLB read port, evaluates the LoongArch INVTLB match rule for the requested op, and clears the E bit of each matching entry through a dedicated clear port. It sits beside the TLB and the address translation logic. It stalls the pipeline while walking, so translation and TLB writes never observe a half-finished invalidate.

---
 rtl/tlb_inv_pkg.sv | 13 +
 rtl/tlb_inv_match.sv | 28 ++
 rtl/tlb_inv_ctrl.sv | 76 +++++++
 tb/tb_tlb_inv_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tlb_inv_pkg.sv
// tlb_inv_pkg: INVTLB op encodings, page sizes and sequencer states
package tlb_inv_pkg;
  localparam logic [4:0] INV_ALL0       = 5'd0;
  localparam logic [4:0] INV_ALL1       = 5'd1;
  localparam logic [4:0] INV_G1         = 5'd2;
  localparam logic [4:0] INV_G0         = 5'd3;
  localparam logic [4:0] INV_G0_ASID    = 5'd4;
  localparam logic [4:0] INV_G0_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GA_VA      = 5'd6;
  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd21;
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
endpackage

// File: rtl/tlb_inv_match.sv
// tlb_inv_match: combinational INVTLB match rule for one TLB entry
module tlb_inv_match
  import tlb_inv_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [9:0]  asid,
  input  logic [18:0] va_vpn,
  input  logic        e,
  input  logic [18:0] vppn,
  input  logic [5:0]  ps,
  input  logic        g,
  input  logic [9:0]  e_asid,
  output logic        match
);
  logic am, vm, rule;
  always_comb begin
    am = e_asid == asid;
    // 4M pages compare only the top 10 VPPN bits; va bit 12 is never part of va_vpn
    vm = ps == PS_4M ? vppn[18:9] == va_vpn[18:9] : vppn == va_vpn;
    rule = (op == INV_ALL0 || op == INV_ALL1) ? 1'b1 :
           op == INV_G1         ? g :
           op == INV_G0         ? !g :
           op == INV_G0_ASID    ? !g && am :
           op == INV_G0_ASID_VA ? !g && am && vm :
           op == INV_GA_VA      ? (g || am) && vm : 1'b0;
    match = e && rule;
  end
endmodule

// File: rtl/tlb_inv_ctrl.sv
// tlb_inv_ctrl: INVTLB sequencer; walks every TLB entry and clears the E bit of matches
module tlb_inv_ctrl
  import tlb_inv_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inv_valid,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [31:0]     inv_va,
  output logic            inv_ready,
  output logic            busy,
  output logic            inv_done,
  output logic            inv_ine,
  output logic [IDXW-1:0] r_index,
  input  logic            r_e,
  input  logic [18:0]     r_vppn,
  input  logic [5:0]      r_ps,
  input  logic            r_g,
  input  logic [9:0]      r_asid,
  output logic            clr_we,
  output logic [IDXW-1:0] clr_index
);
  state_t state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [4:0] op_q, op_d;
  logic [9:0] asid_q, asid_d;
  logic [18:0] vpn_q, vpn_d;
  logic ine_q, ine_d;
  logic accept, match;
  logic unused_va;
  assign unused_va = ^inv_va[12:0];
  tlb_inv_match u_match (
    .op(op_q), .asid(asid_q), .va_vpn(vpn_q),
    .e(r_e), .vppn(r_vppn), .ps(r_ps), .g(r_g), .e_asid(r_asid),
    .match(match)
  );
  always_comb begin
    accept = state_q == IDLE && inv_valid && inv_op <= INV_GA_VA;
    ine_d = state_q == IDLE && inv_valid && inv_op > INV_GA_VA;
    state_d = accept ? WALK :
              (state_q == WALK && idx_q == IDXW'(TLBNUM - 1)) ? DONE :
              state_q == DONE ? IDLE : state_q;
    idx_d = state_q == WALK ? idx_q + 1'b1 : '0;
    op_d = accept ? inv_op : op_q;
    asid_d = accept ? inv_asid : asid_q;
    vpn_d = accept ? inv_va[31:13] : vpn_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      op_q <= '0;
      asid_q <= '0;
      vpn_q <= '0;
      ine_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      op_q <= op_d;
      asid_q <= asid_d;
      vpn_q <= vpn_d;
      ine_q <= ine_d;
    end
  end
  assign inv_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign inv_done = state_q == DONE;
  assign inv_ine = ine_q;
  assign r_index = idx_q;
  assign clr_index = idx_q;
  assign clr_we = state_q == WALK && match;
endmodule

// File: tb/tb_tlb_inv_ctrl.sv
// tb_tlb_inv_ctrl: directed checks of the INVTLB sequencer against a small TLB array
module tb_tlb_inv_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic inv_valid = 1'b0;
  logic [4:0] inv_op = '0;
  logic [9:0] inv_asid = '0;
  logic [31:0] inv_va = '0;
  logic inv_ready, busy, inv_done, inv_ine, clr_we;
  logic [3:0] r_index, clr_index;
  logic r_e, r_g;
  logic [18:0] r_vppn;
  logic [5:0] r_ps;
  logic [9:0] r_asid;
  logic [15:0] tlb_v = '0, cleared;
  logic tlb_rst = 1'b1;
  logic [18:0] vppn_a [16];
  logic [5:0] ps_a [16];
  logic g_a [16];
  logic [9:0] asid_a [16];
  int checks = 0, failures = 0;
  logic [15:0] mask;
  int bcnt, lat, done_n, ine_n, ine_cyc;

  always #5 clk = ~clk;

  tlb_inv_ctrl #(.TLBNUM(16), .IDXW(4)) dut (
    .clk(clk), .reset(reset), .inv_valid(inv_valid), .inv_op(inv_op),
    .inv_asid(inv_asid), .inv_va(inv_va), .inv_ready(inv_ready), .busy(busy),
    .inv_done(inv_done), .inv_ine(inv_ine), .r_index(r_index), .r_e(r_e),
    .r_vppn(r_vppn), .r_ps(r_ps), .r_g(r_g), .r_asid(r_asid),
    .clr_we(clr_we), .clr_index(clr_index)
  );

  assign r_e = tlb_v[r_index] & ~cleared[r_index];
  assign r_vppn = vppn_a[r_index];
  assign r_ps = ps_a[r_index];
  assign r_g = g_a[r_index];
  assign r_asid = asid_a[r_index];

  always @(posedge clk)
    if (tlb_rst) cleared <= '0;
    else if (clr_we) cleared[clr_index] <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] v);
    @(negedge clk);
    tlb_v = v;
    tlb_rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      g_a[i] = 1'b0; asid_a[i] = '0; vppn_a[i] = '0; ps_a[i] = 6'd12;
    end
    @(negedge clk);
    tlb_rst = 1'b0;
  endtask

  task automatic set_ent(input int i, input logic g, input logic [9:0] as,
                         input logic [18:0] vp, input logic [5:0] ps);
    g_a[i] = g; asid_a[i] = as; vppn_a[i] = vp; ps_a[i] = ps;
  endtask

  // Issue one request, then observe a fixed 20-cycle window; noise pokes new requests mid-walk
  task automatic req(input logic [4:0] op, input logic [9:0] as, input logic [31:0] va, input bit noise);
    @(negedge clk);
    inv_valid = 1'b1; inv_op = op; inv_asid = as; inv_va = va;
    mask = '0; bcnt = 0; lat = 0; done_n = 0; ine_n = 0; ine_cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      inv_valid = noise && c >= 3 && c <= 8;
      if (noise) begin inv_op = 5'd0; inv_asid = ~as; inv_va = ~va; end
      if (clr_we) mask[clr_index] = 1'b1;
      if (busy) bcnt++;
      if (inv_done) begin done_n++; lat = c; end
      if (inv_ine) begin ine_n++; ine_cyc = c; end
    end
    inv_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tlb_rst = 1'b0;
    chk("rst_ready", inv_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", inv_done, 0);
    chk("rst_ine", inv_ine, 0);
    chk("rst_clr_we", clr_we, 0);
    chk("rst_r_index", r_index, 0);
    chk("rst_clr_index", clr_index, 0);

    load(16'hFFFF);
    req(5'd0, 10'h0, 32'h0, 0);
    chk("op0_mask", mask, 16'hFFFF);
    chk("op0_latency", lat, 17);
    chk("op0_busy_cycles", bcnt, 17);
    chk("op0_done_pulses", done_n, 1);
    chk("op0_tlb_cleared", cleared, 16'hFFFF);

    load(16'h0088);
    set_ent(3, 1'b1, 10'h0, 19'h0, 6'd12);
    req(5'd1, 10'h0, 32'h0, 0);
    chk("op1_only_valid", mask, 16'h0088);
    load(16'h0088);
    set_ent(3, 1'b1, 10'h0, 19'h0, 6'd12);
    req(5'd2, 10'h0, 32'h0, 0);
    chk("op2_g1", mask, 16'h0008);
    load(16'h0088);
    set_ent(3, 1'b1, 10'h0, 19'h0, 6'd12);
    req(5'd3, 10'h0, 32'h0, 0);
    chk("op3_g0", mask, 16'h0080);

    load(16'h0020);
    set_ent(5, 1'b0, 10'h012, 19'h12345, 6'd12);
    req(5'd4, 10'h012, 32'h0, 0);
    chk("op4_asid", mask, 16'h0020);
    load(16'h0020);
    set_ent(5, 1'b0, 10'h012, 19'h12345, 6'd12);
    req(5'd5, 10'h012, 32'h2468A000, 0);
    chk("op5_hit", mask, 16'h0020);
    load(16'h0020);
    set_ent(5, 1'b0, 10'h012, 19'h12345, 6'd12);
    req(5'd5, 10'h012, 32'h2468B000, 0);
    chk("op5_bit12_ignored", mask, 16'h0020);
    load(16'h0020);
    set_ent(5, 1'b0, 10'h012, 19'h12345, 6'd12);
    req(5'd5, 10'h013, 32'h2468A000, 0);
    chk("op5_asid_miss", mask, 16'h0000);
    load(16'h0020);
    set_ent(5, 1'b0, 10'h012, 19'h12345, 6'd12);
    req(5'd5, 10'h012, 32'h2468C000, 0);
    chk("op5_va_miss", mask, 16'h0000);

    load(16'h0200);
    set_ent(9, 1'b1, 10'h0AB, 19'h2AA00, 6'd21);
    req(5'd6, 10'h3FF, 32'h55400000, 0);
    chk("op6_4m_hit", mask, 16'h0200);
    load(16'h0200);
    set_ent(9, 1'b1, 10'h0AB, 19'h2AA00, 6'd21);
    req(5'd6, 10'h3FF, 32'h55000000, 0);
    chk("op6_4m_miss", mask, 16'h0000);

    load(16'hFFFF);
    req(5'd7, 10'h0, 32'h0, 0);
    chk("op7_ine_pulses", ine_n, 1);
    chk("op7_ine_cycle", ine_cyc, 1);
    chk("op7_busy", bcnt, 0);
    chk("op7_mask", mask, 16'h0000);
    chk("op7_done", done_n, 0);
    req(5'd31, 10'h0, 32'h0, 0);
    chk("op31_ine_pulses", ine_n, 1);
    chk("op31_busy", bcnt, 0);
    chk("op31_mask", mask, 16'h0000);

    load(16'h0088);
    set_ent(3, 1'b1, 10'h0, 19'h0, 6'd12);
    req(5'd2, 10'h0, 32'h0, 1);
    chk("walk_ignore_mask", mask, 16'h0008);
    chk("walk_ignore_busy", bcnt, 17);
    chk("walk_ignore_done", done_n, 1);

    @(negedge clk);
    reset = 1'b1; inv_valid = 1'b1; inv_op = 5'd0;
    @(negedge clk);
    reset = 1'b0; inv_valid = 1'b0;
    chk("rst_vs_valid_busy", busy, 0);
    @(negedge clk);
    chk("rst_vs_valid_busy2", busy, 0);

    load(16'hFFFF);
    @(negedge clk);
    inv_valid = 1'b1; inv_op = 5'd0;
    mask = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      inv_valid = 1'b0;
      if (clr_we) mask[clr_index] = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_mask", mask, 16'h003F);
    chk("midrst_ready", inv_ready, 1);
    chk("midrst_busy", busy, 0);
    done_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (inv_done) done_n++;
    end
    chk("midrst_no_done", done_n, 0);
    chk("midrst_kept", cleared, 16'h003F);
    req(5'd0, 10'h0, 32'h0, 0);
    chk("after_rst_mask", mask, 16'hFFC0);
    chk("after_rst_latency", lat, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
